// File: rtl/local_mem_arbiter.sv
// Local memory arbiter: round-robin grant among NReq requesters with an
// optional lock that keeps ownership across consecutive accesses, a single
// port into a NLocal-entry memory, registered read return and access stats.
module local_mem_arbiter #(
  parameter int MemoryElementWidth = 12,
  parameter int NLocal             = 48,
  parameter int NReq               = 4,
  parameter int AddrWidth          = 6
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NReq-1:0]                    req,
  input  logic [NReq-1:0]                    lock,
  input  logic [NReq-1:0]                    we,
  input  logic [NReq*AddrWidth-1:0]          addr,
  input  logic [NReq*MemoryElementWidth-1:0] wdata,
  output logic [NReq-1:0]                    grant,
  output logic [NReq-1:0]                    rvalid,
  output logic [MemoryElementWidth-1:0]      rdata,
  output logic                               locked,
  output logic                               error,
  output logic [15:0]                        accesses
);

  localparam int PtrW = (NReq > 1) ? $clog2(NReq) : 1;
  localparam int IdxW = (NLocal > 1) ? $clog2(NLocal) : 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                        state_q, state_d;
  logic [PtrW-1:0]               ptr_q, ptr_d;
  logic [PtrW-1:0]               owner_q, owner_d;
  logic [NReq-1:0]               rvalid_q, rvalid_d;
  logic [MemoryElementWidth-1:0] rdata_q, rdata_d;
  logic                          error_q, error_d;
  logic [15:0]                   acc_q, acc_d;

  // Memory is intentionally not reset: contents survive a reset.
  logic [MemoryElementWidth-1:0] mem_q [NLocal];

  logic [NReq-1:0]               grant_s;
  logic [PtrW-1:0]               gidx_s;
  logic                          found_s;
  logic [PtrW:0]                 cand_wide_s;
  logic [PtrW-1:0]               cand_s;
  logic                          any_grant_s;
  logic [AddrWidth-1:0]          sel_addr_s;
  logic [MemoryElementWidth-1:0] sel_wdata_s;
  logic                          sel_we_s;
  logic                          in_range_s;
  logic [IdxW-1:0]               mem_idx_s;

  // Pointer increment with wrap at NReq-1.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    logic [PtrW-1:0] r;
    if (p == PtrW'(NReq - 1)) begin
      r = {PtrW{1'b0}};
    end else begin
      r = p + PtrW'(1);
    end
    return r;
  endfunction

  // One-hot vector with a single bit set at position idx.
  function automatic logic [NReq-1:0] onehot(input logic [PtrW-1:0] idx);
    logic [NReq-1:0] v;
    v      = {NReq{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Grant selection: rotating priority search in IDLE, owner-only in LOCKED.
  always_comb begin
    grant_s     = {NReq{1'b0}};
    gidx_s      = {PtrW{1'b0}};
    found_s     = 1'b0;
    cand_wide_s = {(PtrW+1){1'b0}};
    cand_s      = {PtrW{1'b0}};
    if (!reset) begin
      grant_s = {NReq{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          for (int k = 0; k < NReq; k++) begin
            cand_wide_s = {1'b0, ptr_q} + (PtrW+1)'(k);
            if (cand_wide_s >= (PtrW+1)'(NReq)) begin
              cand_wide_s = cand_wide_s - (PtrW+1)'(NReq);
            end else begin
              cand_wide_s = cand_wide_s;
            end
            cand_s = cand_wide_s[PtrW-1:0];
            if (!found_s && req[cand_s]) begin
              found_s = 1'b1;
              gidx_s  = cand_s;
            end else begin
              found_s = found_s;
            end
          end
          if (found_s) begin
            grant_s = onehot(gidx_s);
          end else begin
            grant_s = {NReq{1'b0}};
          end
        end
        ST_LOCKED: begin
          gidx_s = owner_q;
          if (req[owner_q]) begin
            grant_s = onehot(owner_q);
          end else begin
            grant_s = {NReq{1'b0}};
          end
        end
        default: begin
          grant_s = {NReq{1'b0}};
        end
      endcase
    end
  end

  // Route the granted requester's address, data and direction to the memory port.
  always_comb begin
    sel_addr_s  = {AddrWidth{1'b0}};
    sel_wdata_s = {MemoryElementWidth{1'b0}};
    sel_we_s    = 1'b0;
    for (int i = 0; i < NReq; i++) begin
      if (gidx_s == PtrW'(i)) begin
        sel_addr_s  = addr[i*AddrWidth +: AddrWidth];
        sel_wdata_s = wdata[i*MemoryElementWidth +: MemoryElementWidth];
        sel_we_s    = we[i];
      end else begin
        sel_we_s = sel_we_s;
      end
    end
  end

  assign any_grant_s = |grant_s;
  assign in_range_s  = (sel_addr_s < AddrWidth'(NLocal));
  assign mem_idx_s   = sel_addr_s[IdxW-1:0];

  // Next-state for the arbiter FSM, read return, error flag and access counter.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    rvalid_d = {NReq{1'b0}};
    rdata_d  = rdata_q;
    error_d  = error_q;
    acc_d    = acc_q;

    if (any_grant_s) begin
      if (acc_q == 16'hFFFF) begin
        acc_d = acc_q;
      end else begin
        acc_d = acc_q + 16'd1;
      end
      if (!in_range_s) begin
        error_d = 1'b1;
      end else begin
        error_d = error_q;
      end
      if (!sel_we_s) begin
        rvalid_d = grant_s;
        if (in_range_s) begin
          rdata_d = mem_q[mem_idx_s];
        end else begin
          rdata_d = {MemoryElementWidth{1'b0}};
        end
      end else begin
        rvalid_d = {NReq{1'b0}};
      end
    end else begin
      rvalid_d = {NReq{1'b0}};
    end

    case (state_q)
      ST_IDLE: begin
        if (any_grant_s) begin
          if (lock[gidx_s]) begin
            state_d = ST_LOCKED;
            owner_d = gidx_s;
          end else begin
            ptr_d = next_ptr(gidx_s);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        // The access of the releasing cycle is still performed above.
        if (!req[owner_q] || !lock[owner_q]) begin
          state_d = ST_IDLE;
          ptr_d   = next_ptr(owner_q);
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= {PtrW{1'b0}};
      owner_q  <= {PtrW{1'b0}};
      rvalid_q <= {NReq{1'b0}};
      rdata_q  <= {MemoryElementWidth{1'b0}};
      error_q  <= 1'b0;
      acc_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
      acc_q    <= acc_d;
    end
  end

  // Memory write port; grant is forced low during reset so nothing is written then.
  always_ff @(posedge clock) begin
    if (any_grant_s && sel_we_s && in_range_s) begin
      mem_q[mem_idx_s] <= sel_wdata_s;
    end
  end

  assign grant    = grant_s;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign locked   = (state_q == ST_LOCKED);
  assign error    = error_q;
  assign accesses = acc_q;

endmodule
